// File: rtl/multdiv_pkg.sv
// multdiv_pkg: state encoding, widths and special operand values shared by
// the iterative multiply/divide unit and its bench.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  // Two's-complement magnitude; INT_MIN maps to 0x80000000 read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: operand, start and result signals shared between the
// execute-stage control (master) and the multiply/divide unit (slave).
interface multdiv_unit_if;
  import multdiv_pkg::*;

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/multdiv_unit_div_step.sv
// div_step: one combinational restoring-division step on magnitudes.
// Shifts {rem, quo} left by one and subtracts the divisor when it fits.
module div_step
  import multdiv_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;

  // Trial subtract; the extra top bit keeps the compare exact for any remainder.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_next    = shifted[WIDTH-1:0] - divisor;
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative 32-bit signed multiply (radix-2 Booth) and divide
// (restoring, on magnitudes with sign fix-up). Fixed 33-cycle latency from
// the start edge to the one-cycle data_resultRDY pulse.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  multdiv_unit_if.slave bus
);

  state_t           state, state_next;
  logic [4:0]       cnt;
  logic             start;
  logic             op_mul;

  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] prod, prod_next;
  logic [WIDTH:0]   hi_ext, booth_sum;

  logic [WIDTH-1:0] rem, quo, divisor, rem_next, quo_next;
  logic             neg_quo, div_zero, div_ovf;

  logic [WIDTH-1:0] final_result;
  logic             final_exc;
  logic [WIDTH-1:0] result_q;
  logic             exc_q, rdy_q;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  div_step u_div_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: a start pulse wins in every state (MULT over DIV); an op ends after its last iteration.
  always_comb begin
    state_next = state;
    if (bus.ctrl_MULT) begin
      state_next = MUL;
    end else if (bus.ctrl_DIV) begin
      state_next = DIV;
    end else begin
      case (state)
        MUL, DIV: if (cnt == 5'(ITER - 1)) state_next = DONE;
        DONE:     state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Booth step: add/sub is one bit wider than hi so the sign shifted in stays true even for INT_MIN.
  always_comb begin
    hi_ext    = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    booth_sum = hi_ext;
    case (prod[1:0])
      2'b01:   booth_sum = hi_ext + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = hi_ext - {mcand[WIDTH-1], mcand};
      default: booth_sum = hi_ext;
    endcase
    prod_next = {booth_sum, prod[WIDTH:1]};
  end

  // Operand latch on start, then one multiply or divide iteration per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      op_mul   <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_quo  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (start) begin
      cnt      <= '0;
      op_mul   <= bus.ctrl_MULT;
      mcand    <= bus.data_operandA;
      prod     <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      rem      <= '0;
      quo      <= magnitude(bus.data_operandA);
      divisor  <= magnitude(bus.data_operandB);
      neg_quo  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div_zero <= (bus.data_operandB == '0);
      div_ovf  <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == NEG_ONE);
    end else if (state == MUL) begin
      prod <= prod_next;
      cnt  <= cnt + 5'd1;
    end else if (state == DIV) begin
      rem  <= rem_next;
      quo  <= quo_next;
      cnt  <= cnt + 5'd1;
    end
  end

  // Final value: product low word with overflow when bits 63..31 disagree, or signed quotient with special cases.
  always_comb begin
    final_result = prod[WIDTH:1];
    final_exc    = ~((&prod[2*WIDTH:WIDTH]) | ~(|prod[2*WIDTH:WIDTH]));
    if (!op_mul) begin
      final_result = neg_quo ? -quo : quo;
      final_exc    = 1'b0;
      if (div_zero) begin
        final_result = '0;
        final_exc    = 1'b1;
      end else if (div_ovf) begin
        final_result = INT_MIN;
        final_exc    = 1'b1;
      end
    end
  end

  // Registered outputs: a completed op publishes its result with a one-cycle RDY unless a new start aborts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (state == DONE && !start) begin
        rdy_q    <= 1'b1;
        result_q <= final_result;
        exc_q    <= final_exc;
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed and randomized checks of multdiv_unit against an
// exact-arithmetic reference model (64-bit products, truncating division).
module tb_multdiv_unit;
  import multdiv_pkg::*;

  localparam longint MAX_INT32 = 64'sd2147483647;
  localparam longint MIN_INT32 = -64'sd2147483648;

  logic clock;
  logic reset_n;
  int   totalChecks = 0;
  int   badChecks   = 0;
  int   pulses;

  multdiv_unit_if bus ();

  multdiv_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop if anything hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, got timeout wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h wanted 0x%0h", tag, observed, expected);
    end
  endtask

  // Returns {exception, result} from plain signed arithmetic on the operands.
  function automatic logic [32:0] refModel(input logic isMul, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (isMul) begin
      p = sa * sb;
      return {(p < MIN_INT32) || (p > MAX_INT32), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'h0000_0000};
    p = sa / sb;
    return {(p < MIN_INT32) || (p > MAX_INT32), p[31:0]};
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = NEG_ONE;
      3:       v = INT_MIN;
      4:       v = 32'h7FFF_FFFF;
      5:       v = 32'($urandom_range(0, 200)) - 32'd100;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Called at a negedge: presents a one-cycle start pulse, then scrambles the operands.
  task automatic issueOp(input logic doMul, input logic doDiv, input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = doMul;
    bus.ctrl_DIV      = doDiv;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Waits (bounded) for RDY and checks latency, result and exception; leaves at the RDY negedge.
  task automatic waitResult(input string tag, input logic [32:0] expected);
    int cycles = 0;
    while (bus.data_resultRDY !== 1'b1 && cycles < 60) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput({tag, "/latency"}, 64'(cycles), 64'd33);
    checkOutput({tag, "/result"}, 64'(bus.data_result), 64'(expected[31:0]));
    checkOutput({tag, "/exception"}, 64'(bus.data_exception), 64'(expected[32]));
  endtask

  task automatic applyStimulus(input logic doMul, input logic doDiv, input logic [31:0] a,
                               input logic [31:0] b, input string tag);
    logic [32:0] expected;
    expected = refModel(doMul, a, b);
    @(negedge clock);
    issueOp(doMul, doDiv, a, b);
    waitResult(tag, expected);
    @(negedge clock);
    checkOutput({tag, "/pulse"}, 64'(bus.data_resultRDY), 64'd0);
  endtask

  initial begin
    logic isMul;
    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (2) @(negedge clock);
    checkOutput("reset/result", 64'(bus.data_result), 64'd0);
    checkOutput("reset/exception", 64'(bus.data_exception), 64'd0);
    checkOutput("reset/rdy", 64'(bus.data_resultRDY), 64'd0);
    reset_n = 1'b1;

    // Directed arithmetic cases, including the overflow and divide boundaries.
    applyStimulus(1'b1, 1'b0, 32'd7,         32'hFFFF_FFFD, "mul_7x-3");
    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    applyStimulus(1'b1, 1'b0, INT_MIN,       32'd1,         "mul_intmin_x1");
    applyStimulus(1'b1, 1'b0, INT_MIN,       INT_MIN,       "mul_intmin_sq");
    applyStimulus(1'b1, 1'b0, NEG_ONE,       NEG_ONE,       "mul_neg1_sq");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         "div_-7/2");
    applyStimulus(1'b0, 1'b1, 32'd100,       32'd7,         "div_100/7");
    applyStimulus(1'b0, 1'b1, 32'd5,         32'd0,         "div_by_zero");
    applyStimulus(1'b0, 1'b1, INT_MIN,       NEG_ONE,       "div_ovf");

    // Randomized operations with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      isMul = 1'($urandom_range(0, 1));
      applyStimulus(isMul, ~isMul, pickOperand(), pickOperand(), $sformatf("rand%0d", i));
    end

    // Restart: a DIV ten cycles after a MULT aborts the MULT silently.
    @(negedge clock);
    issueOp(1'b1, 1'b0, 32'd3, 32'd4);
    pulses = 0;
    repeat (9) begin
      if (bus.data_resultRDY === 1'b1) pulses++;
      @(negedge clock);
    end
    issueOp(1'b0, 1'b1, 32'd20, 32'd5);
    waitResult("restart", refModel(1'b0, 32'd20, 32'd5));
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) pulses++;
    end
    checkOutput("restart/extra_rdy", 64'(pulses), 64'd0);

    // Both starts at once: multiply takes priority.
    applyStimulus(1'b1, 1'b1, 32'd6, 32'd3, "both_starts");

    // New start accepted in the same cycle RDY is high.
    @(negedge clock);
    issueOp(1'b1, 1'b0, 32'd11, 32'd13);
    waitResult("b2b_first", refModel(1'b1, 32'd11, 32'd13));
    issueOp(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0001);
    checkOutput("b2b/pulse", 64'(bus.data_resultRDY), 64'd0);
    waitResult("b2b_second", refModel(1'b1, 32'h0001_0000, 32'h0001_0001));

    // Asynchronous reset in the middle of a multiply.
    @(negedge clock);
    issueOp(1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777);
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset/result", 64'(bus.data_result), 64'd0);
    checkOutput("async_reset/exception", 64'(bus.data_exception), 64'd0);
    checkOutput("async_reset/rdy", 64'(bus.data_resultRDY), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    pulses  = 0;
    repeat (45) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) pulses++;
    end
    checkOutput("async_reset/stale_rdy", 64'(pulses), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd2, "post_reset_mul");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
